// File: rtl/apb_uart_rx_slave.sv
// APB completer that deserialises an 8N1 UART line into a small RX FIFO.
// Exposes RXDATA / STATUS / CTRL registers, sticky error flags and a level interrupt.
module apb_uart_rx_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STROBE_WIDTH = 4,
  parameter int CLOCK_RATE   = 100000000,
  parameter int BAUD_RATE    = 9600,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [STROBE_WIDTH-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  input  logic                    UART_rx,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR,
  output logic                    rx_irq
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  rx_state_e          state;
  logic               rx_meta, rx_s;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         bidx;
  logic [7:0]         shreg;
  logic               push_v, ferr_v;
  logic [7:0]         push_d;

  logic               rx_en, irq_en, overrun, frame_err;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               empty, full, setup, pop, do_push, ctrl_we, clr, slv_err;
  logic [7:0]         status;
  logic [DATA_WIDTH-1:0] rd_data;
  logic               unused;

  assign unused = ^{PPROT, PADDR[ADDR_WIDTH-1:4], PADDR[1:0],
                    PWDATA[DATA_WIDTH-1:3], PSTRB[STROBE_WIDTH-1:1]};

  // UART_rx is asynchronous; idle-high reset keeps the FSM from seeing a false start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      cnt    <= '0;
      bidx   <= '0;
      shreg  <= '0;
      push_v <= 1'b0;
      push_d <= '0;
      ferr_v <= 1'b0;
    end else begin
      push_v <= 1'b0;
      ferr_v <= 1'b0;
      if (!rx_en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
          START: if (cnt == CNT_W'(HALF_BIT - 1)) begin
            cnt   <= '0;
            bidx  <= '0;
            state <= rx_s ? IDLE : DATA;
          end else cnt <= cnt + CNT_W'(1);
          DATA: if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            bidx  <= bidx + 3'd1;
            if (bidx == 3'd7) state <= STOP;
          end else cnt <= cnt + CNT_W'(1);
          STOP: if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              push_v <= 1'b1;
              push_d <= shreg;
            end else begin
              ferr_v <= 1'b1;
            end
          end else cnt <= cnt + CNT_W'(1);
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign status  = {frame_err, overrun, full, empty, 4'(level)};
  assign setup   = PSEL & ~PENABLE & ~PREADY;
  assign do_push = push_v & (~full | pop);
  assign clr     = ctrl_we & PWDATA[2];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_data = '0;
    slv_err = 1'b0;
    pop     = 1'b0;
    ctrl_we = 1'b0;
    case (PADDR[3:2])
      2'd0: if (PWRITE || empty) slv_err = 1'b1;
            else begin
              rd_data[7:0] = mem[rd_ptr];
              pop          = setup;
            end
      2'd1: if (PWRITE) slv_err = 1'b1;
            else rd_data[7:0] = status;
      2'd2: if (PWRITE) ctrl_we = setup & PSTRB[0];
            else rd_data[1:0] = {irq_en, rx_en};
      default: slv_err = 1'b1;
    endcase
  end

  // NOTE: the FIFO storage has no reset; level and pointers alone define its contents.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_d;
  end

  // Side effects are taken at the setup edge, so the access cycle already sees PREADY.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PREADY    <= 1'b0;
      PRDATA    <= '0;
      PSLVERR   <= 1'b0;
      rx_irq    <= 1'b0;
      rx_en     <= 1'b1;
      irq_en    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      PREADY  <= setup;
      PRDATA  <= setup ? rd_data : '0;
      PSLVERR <= setup & slv_err;

      if (ctrl_we) begin
        rx_en  <= PWDATA[0];
        irq_en <= PWDATA[1];
      end

      // A fresh error in the clear cycle takes priority over the clear.
      if (push_v && full && !pop) overrun <= 1'b1;
      else if (clr)               overrun <= 1'b0;
      if (ferr_v)                 frame_err <= 1'b1;
      else if (clr)               frame_err <= 1'b0;

      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      rx_irq <= irq_en & (~empty | overrun | frame_err);
    end
  end

endmodule
